// File: rtl/regfile_2r1w_sb.sv
// Register file with two registered, write-first read ports, one write port
// and a per-register pending-write scoreboard with a registered pending count.
module regfile_2r1w_sb #(
  parameter int DATA_BITS = 32,
  parameter int ADDR_BITS = 5,
  parameter int ZERO_REG  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 re_a,
  input  logic [ADDR_BITS-1:0] raddr_a,
  output logic [DATA_BITS-1:0] rdata_a,
  output logic                 rhaz_a,
  input  logic                 re_b,
  input  logic [ADDR_BITS-1:0] raddr_b,
  output logic [DATA_BITS-1:0] rdata_b,
  output logic                 rhaz_b,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic                 rsv,
  input  logic [ADDR_BITS-1:0] rsv_addr,
  output logic [ADDR_BITS:0]   pend_cnt
);

  localparam int NUM_REGS = 2 ** ADDR_BITS;

  logic [DATA_BITS-1:0] regs_q [NUM_REGS];
  logic [DATA_BITS-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]  pend_q, pend_d;
  logic [ADDR_BITS:0]   pend_cnt_q, pend_cnt_d;
  logic [DATA_BITS-1:0] rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
  logic                 rhaz_a_q, rhaz_a_d, rhaz_b_q, rhaz_b_d;
  logic                 wr_en, rsv_en;

  // Qualify write and reserve: register 0 is inert when hardwired to zero.
  always_comb begin
    wr_en  = we  && !((ZERO_REG != 0) && (waddr == '0));
    rsv_en = rsv && !((ZERO_REG != 0) && (rsv_addr == '0));
  end

  // Next array and scoreboard state; a reserve on the same edge beats the
  // write's clear so back-to-back producers of one register stay pending.
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    if (wr_en) begin
      regs_d[waddr] = wdata;
      pend_d[waddr] = 1'b0;
    end
    if (rsv_en) begin
      pend_d[rsv_addr] = 1'b1;
    end
  end

  // Popcount of the post-update pending bits.
  always_comb begin
    pend_cnt_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      pend_cnt_d = pend_cnt_d + {{ADDR_BITS{1'b0}}, pend_d[i]};
    end
  end

  // Port A read: flat indexed select with the write bypass compared in parallel.
  always_comb begin
    rdata_a_d = rdata_a_q;
    rhaz_a_d  = rhaz_a_q;
    if (re_a) begin
      if ((ZERO_REG != 0) && (raddr_a == '0)) begin
        rdata_a_d = '0;
        rhaz_a_d  = 1'b0;
      end else begin
        rdata_a_d = (wr_en && (waddr == raddr_a)) ? wdata : regs_q[raddr_a];
        rhaz_a_d  = pend_d[raddr_a];
      end
    end
  end

  // Port B read, identical structure to port A.
  always_comb begin
    rdata_b_d = rdata_b_q;
    rhaz_b_d  = rhaz_b_q;
    if (re_b) begin
      if ((ZERO_REG != 0) && (raddr_b == '0)) begin
        rdata_b_d = '0;
        rhaz_b_d  = 1'b0;
      end else begin
        rdata_b_d = (wr_en && (waddr == raddr_b)) ? wdata : regs_q[raddr_b];
        rhaz_b_d  = pend_d[raddr_b];
      end
    end
  end

  // State registers; everything clears asynchronously so no X ever reads out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      pend_q     <= '0;
      pend_cnt_q <= '0;
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
      rhaz_a_q   <= 1'b0;
      rhaz_b_q   <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      pend_q     <= pend_d;
      pend_cnt_q <= pend_cnt_d;
      rdata_a_q  <= rdata_a_d;
      rdata_b_q  <= rdata_b_d;
      rhaz_a_q   <= rhaz_a_d;
      rhaz_b_q   <= rhaz_b_d;
    end
  end

  assign rdata_a  = rdata_a_q;
  assign rdata_b  = rdata_b_q;
  assign rhaz_a   = rhaz_a_q;
  assign rhaz_b   = rhaz_b_q;
  assign pend_cnt = pend_cnt_q;

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// Bench for regfile_2r1w_sb: default instance checked against a behavioural
// model through an expected/observed queue pair, plus a ZERO_REG=0 instance
// and a narrow 8x8 instance.
module tb_regfile_2r1w_sb;

  typedef struct packed {
    logic [31:0] rda;
    logic [31:0] rdb;
    logic        ha;
    logic        hb;
    logic [5:0]  cnt;
  } samp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic        re_a = 0, re_b = 0, we = 0, rsv = 0;
  logic [4:0]  raddr_a = 0, raddr_b = 0, waddr = 0, rsv_addr = 0;
  logic [31:0] wdata = 0, rdata_a, rdata_b;
  logic        rhaz_a, rhaz_b;
  logic [5:0]  pend_cnt;

  // ZERO_REG=0 instance
  logic        nz_re_a = 0, nz_re_b = 0, nz_we = 0, nz_rsv = 0;
  logic [4:0]  nz_raddr_a = 0, nz_raddr_b = 0, nz_waddr = 0, nz_rsv_addr = 0;
  logic [31:0] nz_wdata = 0, nz_rdata_a, nz_rdata_b;
  logic        nz_rhaz_a, nz_rhaz_b;
  logic [5:0]  nz_pend_cnt;

  // 8-bit data, 3-bit address instance
  logic        s_re_a = 0, s_re_b = 0, s_we = 0, s_rsv = 0;
  logic [2:0]  s_raddr_a = 0, s_raddr_b = 0, s_waddr = 0, s_rsv_addr = 0;
  logic [7:0]  s_wdata = 0, s_rdata_a, s_rdata_b;
  logic        s_rhaz_a, s_rhaz_b;
  logic [3:0]  s_pend_cnt;

  regfile_2r1w_sb dut (
    .clk(clk), .rst_n(rst_n),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a), .rhaz_a(rhaz_a),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b), .rhaz_b(rhaz_b),
    .we(we), .waddr(waddr), .wdata(wdata),
    .rsv(rsv), .rsv_addr(rsv_addr), .pend_cnt(pend_cnt)
  );

  regfile_2r1w_sb #(.ZERO_REG(0)) dut_nz (
    .clk(clk), .rst_n(rst_n),
    .re_a(nz_re_a), .raddr_a(nz_raddr_a), .rdata_a(nz_rdata_a), .rhaz_a(nz_rhaz_a),
    .re_b(nz_re_b), .raddr_b(nz_raddr_b), .rdata_b(nz_rdata_b), .rhaz_b(nz_rhaz_b),
    .we(nz_we), .waddr(nz_waddr), .wdata(nz_wdata),
    .rsv(nz_rsv), .rsv_addr(nz_rsv_addr), .pend_cnt(nz_pend_cnt)
  );

  regfile_2r1w_sb #(.DATA_BITS(8), .ADDR_BITS(3)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .re_a(s_re_a), .raddr_a(s_raddr_a), .rdata_a(s_rdata_a), .rhaz_a(s_rhaz_a),
    .re_b(s_re_b), .raddr_b(s_raddr_b), .rdata_b(s_rdata_b), .rhaz_b(s_rhaz_b),
    .we(s_we), .waddr(s_waddr), .wdata(s_wdata),
    .rsv(s_rsv), .rsv_addr(s_rsv_addr), .pend_cnt(s_pend_cnt)
  );

  int vectors = 0;
  int miscompares = 0;

  samp_t exp_q[$];
  samp_t obs_q[$];

  // model of the default instance
  logic [31:0] m_regs [32];
  bit          m_pend [32];
  logic [31:0] m_rda, m_rdb;
  bit          m_ha, m_hb;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 0;
    end
    m_rda = '0; m_rdb = '0; m_ha = 0; m_hb = 0;
  endtask

  // One clock of the default instance: drive, predict, sample.
  task automatic step(input bit ra_en, input logic [4:0] ra,
                      input bit rb_en, input logic [4:0] rb,
                      input bit w, input logic [4:0] wa, input logic [31:0] wd,
                      input bit r, input logic [4:0] radr);
    samp_t e, o;
    int c;
    re_a = ra_en; raddr_a = ra; re_b = rb_en; raddr_b = rb;
    we = w; waddr = wa; wdata = wd; rsv = r; rsv_addr = radr;
    if (w && wa != 0) begin
      m_regs[wa] = wd;
      m_pend[wa] = 0;
    end
    if (r && radr != 0) m_pend[radr] = 1;
    if (ra_en) begin m_rda = m_regs[ra]; m_ha = m_pend[ra]; end
    if (rb_en) begin m_rdb = m_regs[rb]; m_hb = m_pend[rb]; end
    c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_pend[i]);
    e.rda = m_rda; e.rdb = m_rdb; e.ha = m_ha; e.hb = m_hb; e.cnt = 6'(c);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    o.rda = rdata_a; o.rdb = rdata_b; o.ha = rhaz_a; o.hb = rhaz_b; o.cnt = pend_cnt;
    obs_q.push_back(o);
    re_a = 0; re_b = 0; we = 0; rsv = 0;
  endtask

  task automatic test_reset();
    samp_t e, o;
    rst_n = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({rdata_a, rdata_b, rhaz_a, rhaz_b, pend_cnt} !== '0) begin
      miscompares++;
      $display("FAIL reset_initial: got rda=%h rdb=%h ha=%b hb=%b cnt=%0d, expected all zero",
               rdata_a, rdata_b, rhaz_a, rhaz_b, pend_cnt);
    end
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    step(0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 7);
    step(1, 5, 1, 7, 0, 0, 0, 0, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL reset_pre: got rda=%h rdb=%h ha=%b hb=%b cnt=%0d, expected rda=%h rdb=%h ha=%b hb=%b cnt=%0d",
                 o.rda, o.rdb, o.ha, o.hb, o.cnt, e.rda, e.rdb, e.ha, e.hb, e.cnt);
      end
    end
    // asynchronous reset pulse between edges
    rst_n = 0;
    #1;
    vectors++;
    if ({rdata_a, rhaz_a, rdata_b, rhaz_b, pend_cnt} !== '0) begin
      miscompares++;
      $display("FAIL reset_async: got rda=%h ha=%b rdb=%h hb=%b cnt=%0d, expected all zero",
               rdata_a, rhaz_a, rdata_b, rhaz_b, pend_cnt);
    end
    model_reset();
    #2;
    rst_n = 1;
    step(1, 5, 1, 7, 0, 0, 0, 0, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL reset_post: got rda=%h rdb=%h ha=%b hb=%b cnt=%0d, expected rda=%h rdb=%h ha=%b hb=%b cnt=%0d",
                 o.rda, o.rdb, o.ha, o.hb, o.cnt, e.rda, e.rdb, e.ha, e.hb, e.cnt);
      end
    end
  endtask

  task automatic test_bypass();
    samp_t e, o;
    step(0, 0, 0, 0, 1, 3, 32'h11111111, 0, 0);
    step(1, 3, 1, 3, 1, 3, 32'h22222222, 0, 0);
    step(0, 4, 0, 6, 1, 4, 32'h33333333, 0, 0);
    step(1, 4, 0, 0, 0, 0, 0, 0, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL bypass: got rda=%h rdb=%h ha=%b hb=%b cnt=%0d, expected rda=%h rdb=%h ha=%b hb=%b cnt=%0d",
                 o.rda, o.rdb, o.ha, o.hb, o.cnt, e.rda, e.rdb, e.ha, e.hb, e.cnt);
      end
    end
  endtask

  task automatic test_zero_reg();
    samp_t e, o;
    step(0, 0, 1, 0, 1, 0, 32'hFFFFFFFF, 1, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL zero_reg: got rda=%h rdb=%h ha=%b hb=%b cnt=%0d, expected rda=%h rdb=%h ha=%b hb=%b cnt=%0d",
                 o.rda, o.rdb, o.ha, o.hb, o.cnt, e.rda, e.rdb, e.ha, e.hb, e.cnt);
      end
    end
    // ZERO_REG=0: register 0 is an ordinary register
    nz_we = 1; nz_waddr = 0; nz_wdata = 32'hFFFFFFFF; nz_rsv = 1; nz_rsv_addr = 0;
    nz_re_b = 1; nz_raddr_b = 0;
    @(posedge clk); #1;
    nz_we = 0; nz_rsv = 0;
    vectors++;
    if (nz_rdata_b !== 32'hFFFFFFFF || nz_rhaz_b !== 1'b1 || nz_pend_cnt !== 6'd1) begin
      miscompares++;
      $display("FAIL nz_r0_write: got rdb=%h hb=%b cnt=%0d, expected rdb=ffffffff hb=1 cnt=1",
               nz_rdata_b, nz_rhaz_b, nz_pend_cnt);
    end
    nz_we = 1; nz_wdata = 32'h0BADF00D;
    @(posedge clk); #1;
    nz_we = 0; nz_re_b = 0;
    vectors++;
    if (nz_rdata_b !== 32'h0BADF00D || nz_rhaz_b !== 1'b0 || nz_pend_cnt !== 6'd0) begin
      miscompares++;
      $display("FAIL nz_r0_clear: got rdb=%h hb=%b cnt=%0d, expected rdb=0badf00d hb=0 cnt=0",
               nz_rdata_b, nz_rhaz_b, nz_pend_cnt);
    end
  endtask

  task automatic test_collision();
    samp_t e, o;
    step(0, 0, 0, 0, 0, 0, 0, 1, 9);
    step(1, 9, 1, 9, 1, 9, 32'hA5A5A5A5, 1, 9);
    step(1, 9, 1, 9, 1, 9, 32'h5A5A5A5A, 0, 0);
    step(1, 9, 1, 9, 0, 0, 0, 0, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL collision: got rda=%h rdb=%h ha=%b hb=%b cnt=%0d, expected rda=%h rdb=%h ha=%b hb=%b cnt=%0d",
                 o.rda, o.rdb, o.ha, o.hb, o.cnt, e.rda, e.rdb, e.ha, e.hb, e.cnt);
      end
    end
  endtask

  task automatic test_full_scoreboard();
    samp_t e, o;
    for (int i = 1; i < 32; i++) step(1, 5'(i), 1, 5'(i - 1), 0, 0, 0, 1, 5'(i));
    step(1, 31, 0, 0, 0, 0, 0, 1, 31);
    for (int i = 1; i < 32; i++) step(0, 0, 1, 5'(i), 1, 5'(i), 32'h01010101 * i, 0, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL full_sb: got rda=%h rdb=%h ha=%b hb=%b cnt=%0d, expected rda=%h rdb=%h ha=%b hb=%b cnt=%0d",
                 o.rda, o.rdb, o.ha, o.hb, o.cnt, e.rda, e.rdb, e.ha, e.hb, e.cnt);
      end
    end
  endtask

  task automatic test_back_to_back();
    samp_t e, o;
    // narrow address range so bypasses and collisions are frequent
    for (int n = 0; n < 200; n++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL back_to_back: got rda=%h rdb=%h ha=%b hb=%b cnt=%0d, expected rda=%h rdb=%h ha=%b hb=%b cnt=%0d",
                 o.rda, o.rdb, o.ha, o.hb, o.cnt, e.rda, e.rdb, e.ha, e.hb, e.cnt);
      end
    end
  endtask

  task automatic test_width_sweep();
    logic [7:0] s_ref [8];
    s_ref[0] = '0;
    for (int i = 0; i < 8; i++) begin
      s_we = 1; s_waddr = 3'(i); s_wdata = 8'($urandom_range(1, 255));
      if (i != 0) s_ref[i] = s_wdata;
      @(posedge clk); #1;
      s_we = 0;
    end
    for (int i = 0; i < 8; i++) begin
      s_re_a = 1; s_raddr_a = 3'(i); s_re_b = 1; s_raddr_b = 3'(7 - i);
      @(posedge clk); #1;
      s_re_a = 0; s_re_b = 0;
      vectors++;
      if (s_rdata_a !== s_ref[i] || s_rdata_b !== s_ref[7 - i]) begin
        miscompares++;
        $display("FAIL width_read r%0d/r%0d: got %h/%h, expected %h/%h",
                 i, 7 - i, s_rdata_a, s_rdata_b, s_ref[i], s_ref[7 - i]);
      end
    end
    for (int i = 0; i < 8; i++) begin
      s_rsv = 1; s_rsv_addr = 3'(i);
      @(posedge clk); #1;
      s_rsv = 0;
    end
    vectors++;
    if (s_pend_cnt !== 4'd7) begin
      miscompares++;
      $display("FAIL width_pend_max: got cnt=%0d, expected 7", s_pend_cnt);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_bypass();
    test_zero_reg();
    test_collision();
    test_full_scoreboard();
    test_back_to_back();
    test_width_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_2r1w_sb.md
# regfile_2r1w_sb

Parametrised register file for the RISCAT datapath: 2 synchronous read ports, 1 write port, and a per-register pending-write scoreboard. It replaces ad-hoc wide mux/demux trees around the register array. Reads are registered and write-first, so decode sees forwarded writeback data and a hazard flag one cycle after presenting an address.

## Interface
- DATA_BITS, 32, register width
- ADDR_BITS, 5, address width; NUM_REGS = 2**ADDR_BITS
- ZERO_REG, 1, when 1, register 0 reads as 0 and is never written or reserved
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- re_a, re_b  in  1 each  read enable, port A / port B
- raddr_a, raddr_b  in  ADDR_BITS each  read address
- rdata_a, rdata_b  out  DATA_BITS each  registered read data
- rhaz_a, rhaz_b  out  1 each  registered pending flag for the addressed register
- we  in  1  write enable
- waddr  in  ADDR_BITS  write address
- wdata  in  DATA_BITS  write data
- rsv  in  1  reserve enable: mark register as awaiting writeback
- rsv_addr  in  ADDR_BITS  register to reserve
- pend_cnt  out  ADDR_BITS+1  number of registers currently pending

## Operation
- Reset (rst_n low, asynchronous): every register = 0; all pending bits = 0; rdata_a/b = 0; rhaz_a/b = 0; pend_cnt = 0. Outputs stay at these values while rst_n is low.
- Write: on an edge with we=1, reg[waddr] <= wdata and pending[waddr] <= 0.
  - Ignored entirely when ZERO_REG=1 and waddr=0.
- Reserve: on an edge with rsv=1, pending[rsv_addr] <= 1.
  - Ignored when ZERO_REG=1 and rsv_addr=0.
  - Reserving an already-pending register leaves it pending; no count change.
- Same edge, we=1 and rsv=1 with waddr==rsv_addr: the write updates data, but the reserve wins, so the pending bit ends at 1. This covers back-to-back producers of the same rd.
- Writing a non-pending register updates data only; pending stays 0.
- Read, per port independently: on an edge with re=1:
  - rdata <= value of reg[raddr] after this edge's write (write-first bypass: equal addresses return wdata).
  - rhaz <= pending[raddr] after this edge's write and reserve updates.
  - ZERO_REG=1 and raddr=0: rdata <= 0 and rhaz <= 0, regardless of we/wdata.
- re=0: rdata/rhaz hold their previous value.
- Both ports may read the same address in the same cycle with identical results.
- pend_cnt: registered popcount of pending bits after the edge's updates. Maximum is NUM_REGS, or NUM_REGS-1 when ZERO_REG=1; width is ADDR_BITS+1 so it never wraps.
- No X propagation: unreserved, unwritten registers read 0 after reset.

## Timing
- Read latency: 1 cycle. Address presented in cycle N, data and hazard valid after the edge ending cycle N, stable through cycle N+1.
- Write latency: 0 cycles to the same-edge read (bypass). The array is updated at the edge.
- Reserve to hazard visibility: same edge. A read issued in the reserve cycle sees rhaz=1.
- Throughput: 2 reads + 1 write + 1 reserve per cycle, with no stalls and no backpressure.
- Reset deassertion: the first functional edge is the first rising clk with rst_n high. Deassertion is synchronised externally; this block adds no reset synchroniser.
- Critical path: raddr -> NUM_REGS:1 mux -> bypass compare -> flop. The mux is a flat indexed select; the bypass compare runs in parallel with it.

## Test plan
- Reset mid-operation: write 0xDEADBEEF to r5, reserve r7, read r5 on port A, then pulse rst_n low between edges -> rdata_a=0, rhaz_a=0 and pend_cnt=0 immediately (asynchronously); after release, reading r5 returns 0.
- Write-first bypass: r3=0x11111111; same cycle we=1, waddr=3, wdata=0x22222222, re_a=1, raddr_a=3 -> next cycle rdata_a=0x22222222. Then re_a=0 with the address changed -> rdata_a holds 0x22222222.
- Zero register, ZERO_REG=1: write 0xFFFFFFFF to r0 and reserve r0, while port B reads r0 that cycle and the next -> rdata_b=0, rhaz_b=0, pend_cnt=0. Repeat with ZERO_REG=0 -> rdata_b=0xFFFFFFFF after the write.
- Scoreboard collision: reserve r9 (pend_cnt=1); next cycle we to r9 with 0xA5A5A5A5 plus rsv to r9, reading r9 on both ports -> both rdata=0xA5A5A5A5, both rhaz=1, pend_cnt=1. Next cycle write r9 alone -> rhaz=0 on re-read, pend_cnt=0.
- Full scoreboard: reserve r1..r31 on consecutive cycles -> pend_cnt reaches 31; re-reserve r31 -> stays 31. Write all 31 -> pend_cnt returns to 0.
- Width sweep: instantiate DATA_BITS=8, ADDR_BITS=3, then write/read all 8 registers with random data against a reference model -> no mismatch; pend_cnt max is 7.
